fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset; parameters and ports SHALL be exactly as listed in REQ-002 to REQ-015.
REQ-002 RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
REQ-003 NOP_INSN, 32'h0000_0013, value driven on ir when ir_valid=0 (addi x0,x0,0).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  single-cycle fetch request strobe; memory always accepts.
REQ-007 imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  response strobe for the one outstanding request, at least 1 cycle after imem_req.
REQ-009 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-012 halt_req  input  1  level; stop issuing new fetches.
REQ-013 ir_valid / ir / ir_pc  output  1/32/32  head instruction word and its PC, presented to the decoder.
REQ-014 ir_ready  input  1  decoder accepts head entry when ir_valid and ir_ready are both 1.
REQ-015 halted  output  1  high when no fetch is outstanding and fetching is stopped.

Function
REQ-016 Instruction buffer SHALL be a 2-entry FIFO of {pc, insn}; ir_valid=1 iff non-empty; ir/ir_pc SHALL show the head entry combinationally.
REQ-017 When empty, ir SHALL be NOP_INSN and ir_pc SHALL be 0.
REQ-018 States: IDLE (none outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard), HALTED.
REQ-019 In IDLE, with halt_req=0, no redirect, and occupancy+pending<2, the block SHALL assert imem_req with imem_addr=fetch_pc, set fetch_pc+=4 (32-bit wrap, 32'hFFFF_FFFC -> 0), and go to WAIT.
REQ-020 At most one request SHALL be outstanding; imem_req SHALL never assert in WAIT, DROP or HALTED.
REQ-021 In WAIT, on imem_rvalid, {request pc, imem_rdata} SHALL be enqueued, the state SHALL return to IDLE, and a new request MAY issue in the same cycle if REQ-019 holds with post-update occupancy.
REQ-022 Enqueue and dequeue in the same cycle SHALL keep occupancy unchanged; enqueue when full SHALL be impossible by REQ-019.
REQ-023 On redirect_valid, the FIFO SHALL flush (ir_valid=0 next cycle), fetch_pc SHALL load {redirect_pc[31:2],2'b00}, WAIT SHALL go to DROP, and IDLE SHALL stay IDLE with no request in that cycle.
REQ-024 A redirect in the same cycle as imem_rvalid SHALL discard that response; a redirect in the same cycle as a dequeue SHALL flush anyway.
REQ-025 In DROP, imem_rvalid SHALL be discarded and the state SHALL go to IDLE; a further redirect SHALL only update fetch_pc.
REQ-026 Latency: redirect at cycle N with nothing outstanding -> imem_req at N+1; rvalid at cycle M -> ir_valid at M+1.
REQ-027 halt_req=1 SHALL block new requests; an outstanding WAIT response SHALL still be enqueued; when no request is outstanding the state SHALL go to HALTED.
REQ-028 The FIFO SHALL keep draining to the decoder in HALTED.
REQ-029 halted=1 only in HALTED; HALTED SHALL exit only on rst; redirect in HALTED SHALL update fetch_pc and flush the FIFO.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, fetch_pc=RESET_PC, FIFO empty, ir_valid=0, ir=NOP_INSN, ir_pc=0, imem_req=0, halted=0.
REQ-031 Reset mid-operation SHALL abandon any outstanding request; an imem_rvalid arriving after reset with state IDLE SHALL be ignored.
REQ-032 The first imem_req SHALL assert in the first clock edge cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-033 Reset release, memory latency 1, ir_ready=1 -> addresses 0,4,8 issued every 2 cycles; ir_pc follows 0,4,8 with matching insn.
REQ-034 ir_ready=0 for 10 cycles -> exactly 2 entries buffered, no third imem_req; ir_ready=1 -> entries pc 0 then 4 in order.
REQ-035 Redirect to 32'h0000_0102 while WAIT -> that response dropped, FIFO flushed, next imem_addr=32'h0000_0100.
REQ-036 Redirect in the same cycle as imem_rvalid -> response not enqueued, ir_valid=0 next cycle.
REQ-037 halt_req during WAIT -> response enqueued, then halted=1, no further imem_req; FIFO drains; only rst restarts at RESET_PC.
REQ-038 fetch_pc=32'hFFFF_FFFC -> next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry {pc, insn} buffer
// Ports: clk/rst (async active-high), imem_req/imem_addr out, imem_rvalid/imem_rdata in,
//        redirect_valid/redirect_pc in, halt_req in, ir_valid/ir/ir_pc out with ir_ready in, halted out
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;
    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_pc [2];
    logic [31:0] r_insn [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        w_enq;
    logic        w_deq;
    logic        w_tail;

    // Only issued from IDLE, so nothing is pending and occupancy alone bounds the buffer.
    assign imem_req  = !rst && r_state == IDLE && !halt_req && !redirect_valid && r_count != 2'd2;
    assign imem_addr = r_fetch_pc;
    assign w_enq     = r_state == WAIT && imem_rvalid && !redirect_valid;
    assign ir_valid  = r_count != 2'd0;
    assign w_deq     = ir_valid && ir_ready;
    // With occupancy <= 1 at enqueue, the free slot is the one after the head.
    assign w_tail    = r_head ^ r_count[0];
    assign ir        = ir_valid ? r_insn[r_head] : NOP_INSN;
    assign ir_pc     = ir_valid ? r_pc[r_head] : 32'h0;
    assign halted    = r_state == HALTED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (redirect_valid)
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (imem_req)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (imem_req)
                r_req_pc <= r_fetch_pc;
            // A response landing with a redirect is consumed here (not enqueued), so it
            // must not move to DROP, which would wait for a response that never comes.
            case (r_state)
                IDLE:    r_state <= halt_req ? HALTED : imem_req ? WAIT : IDLE;
                WAIT:    r_state <= imem_rvalid ? (halt_req ? HALTED : IDLE) : redirect_valid ? DROP : WAIT;
                DROP:    r_state <= imem_rvalid ? (halt_req ? HALTED : IDLE) : DROP;
                default: r_state <= HALTED;
            endcase
            if (redirect_valid) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
            end else begin
                r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
                if (w_deq)
                    r_head <= ~r_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[w_tail]   <= r_req_pc;
            r_insn[w_tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, hand sequences and randomized run against a queue-based model
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        halted;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    // Reference model: buffer contents, whether a request is in flight and whether
    // its answer is to be thrown away, next fetch address, and the sticky halt flag.
    ent_t        q[$];
    logic        outst;
    logic        disc;
    logic        mhalt;
    logic [31:0] mpc;
    logic [31:0] mreq;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        ir_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_ir", ir, NOP);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_halted", halted, 0);
        q.delete();
        outst = 0;
        disc = 0;
        mhalt = 0;
        mpc = 32'h0;
        mreq = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input logic rv, input logic [31:0] rd, input logic rdir,
                       input logic [31:0] rpc, input logic hlt, input logic rdy);
        logic er;
        logic resp;
        logic keep;
        ent_t h;
        @(negedge clk);
        imem_rvalid = rv;
        imem_rdata = rd;
        redirect_valid = rdir;
        redirect_pc = rpc;
        halt_req = hlt;
        ir_ready = rdy;
        #1;
        h = q.size() != 0 ? q[0] : '{32'h0, NOP};
        er = !mhalt && !outst && !hlt && !rdir && q.size() < 2;
        chk("req", imem_req, er);
        if (er)
            chk("addr", imem_addr, mpc);
        chk("valid", ir_valid, q.size() != 0);
        chk("ir", ir, h.insn);
        chk("ir_pc", ir_pc, h.pc);
        chk("halted", halted, mhalt);
        resp = outst && rv;
        keep = resp && !disc && !rdir;
        if (rdir)
            q.delete();
        else begin
            if (q.size() != 0 && rdy)
                void'(q.pop_front());
            if (keep)
                q.push_back('{mreq, rd});
        end
        if (resp) begin
            outst = 0;
            disc = 0;
        end else if (rdir && outst)
            disc = 1;
        if (rdir)
            mpc = {rpc[31:2], 2'b00};
        else if (er) begin
            mreq = mpc;
            mpc = mpc + 32'd4;
            outst = 1;
        end
        if (hlt && !outst)
            mhalt = 1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdir;
        logic [31:0] rpc;
        logic        rdy;
        logic        er;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eir;
    } vec_t;

    vec_t tv[16];

    initial begin
        logic        mbusy;
        int          mcnt;
        logic        rv;
        logic        rdir;
        logic        hen;
        logic [31:0] rpc;

        tv[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   NOP};
        tv[1]  = '{1'b1, 32'hA000_0000, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tv[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'hA000_0000};
        tv[3]  = '{1'b1, 32'hA000_0004, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tv[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'hA000_0004};
        tv[5]  = '{1'b1, 32'hA000_0008, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tv[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   32'hA000_0008};
        tv[7]  = '{1'b1, 32'hA000_000C, 1'b1, 32'h102, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tv[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   NOP};
        tv[9]  = '{1'b1, 32'hB0B0_B0B0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tv[10] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'hB0B0_B0B0};
        tv[11] = '{1'b1, 32'hC0C0_C0C0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'hB0B0_B0B0};
        tv[12] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'hB0B0_B0B0};
        tv[13] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'hB0B0_B0B0};
        tv[14] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'hB0B0_B0B0};
        tv[15] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 32'hC0C0_C0C0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(tv[i].rv, tv[i].rd, tv[i].rdir, tv[i].rpc, 1'b0, tv[i].rdy);
            chk($sformatf("tv%0d_req", i), imem_req, tv[i].er);
            if (tv[i].er)
                chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].ea);
            chk($sformatf("tv%0d_valid", i), ir_valid, tv[i].ev);
            chk($sformatf("tv%0d_ir_pc", i), ir_pc, tv[i].epc);
            chk($sformatf("tv%0d_ir", i), ir, tv[i].eir);
        end

        // Redirect while a request is in flight: its answer is dropped, refetch from 0x100.
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1);
        chk("r35_redir_req", imem_req, 0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r35_drop_req", imem_req, 0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r35_req", imem_req, 1);
        chk("r35_addr", imem_addr, 32'h100);
        chk("r35_flushed", ir_valid, 0);
        cyc(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r35_ir_pc", ir_pc, 32'h100);
        chk("r35_ir", ir, 32'h1234_5678);

        // Halt while waiting: response kept, then halted with the buffer draining.
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("r37_wait_halted", halted, 0);
        cyc(1'b1, 32'h0D0D_0D0D, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("r37_halted", halted, 1);
        chk("r37_ir", ir, 32'h0D0D_0D0D);
        chk("r37_no_req", imem_req, 0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r37_drained", ir_valid, 0);
        chk("r37_stay_halted", halted, 1);
        chk("r37_stay_no_req", imem_req, 0);
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r37_restart_req", imem_req, 1);
        chk("r37_restart_addr", imem_addr, 32'h0);

        // Fetch address wraps past the top of the address space.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r38_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("r38_wrap_req", imem_req, 1);
        chk("r38_wrap_addr", imem_addr, 32'h0);
        chk("r38_ir_pc", ir_pc, 32'hFFFF_FFFC);

        // Random traffic; the memory keeps any in-flight answer across resets so stale
        // responses after reset are exercised too.
        mbusy = 0;
        mcnt = 0;
        for (int c = 0; c < 8; c++) begin
            do_reset();
            hen = c[0];
            for (int k = 0; k < 300; k++) begin
                rv = mbusy && mcnt == 0;
                rdir = $urandom_range(0, 9) == 0;
                rpc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom();
                cyc(rv, $urandom(), rdir, rpc, hen && $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 7);
                if (rv)
                    mbusy = 0;
                else if (mbusy)
                    mcnt--;
                if (imem_req) begin
                    mbusy = 1;
                    mcnt = $urandom_range(0, 2);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
